// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, constants and types for the instruction fetch unit
package inst_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam logic [InstBus-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry {pc, inst} FIFO with push/pop/clear
module fetch_queue
    import inst_fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_do_pop;
    logic         w_do_push;

    assign o_empty   = (r_count == 2'd0);
    assign o_full    = (r_count == 2'd2);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC generation, single-outstanding instruction memory requests, IF/ID presentation
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic [InstAddrBus-1:0] i_new_pc,
    input  logic                   i_branch_flag,
    input  logic [InstAddrBus-1:0] i_branch_target,
    output logic                   o_inst_req,
    output logic [InstAddrBus-1:0] o_inst_addr,
    input  logic                   i_inst_ack,
    input  logic [InstBus-1:0]     i_inst_rdata,
    output logic                   o_if_valid,
    output logic [InstAddrBus-1:0] o_if_pc,
    output logic [InstBus-1:0]     o_if_inst
);

    fetch_state_t           r_state;
    logic [InstAddrBus-1:0] r_fetch_pc;
    logic [InstAddrBus-1:0] r_inst_addr;
    logic                   r_inst_req;

    fetch_entry_t           w_push_data;
    fetch_entry_t           w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [1:0]             w_count;
    logic                   w_redirect;
    logic [InstAddrBus-1:0] w_target;
    logic                   w_ack;
    logic                   w_pop;
    logic                   w_push;
    logic [2:0]             w_count_after;
    logic                   w_room_after;
    logic [InstAddrBus-1:0] w_pc_next;

    assign w_redirect    = i_flush || i_branch_flag;
    assign w_target      = word_align(i_flush ? i_new_pc : i_branch_target);
    assign w_ack         = i_inst_ack && r_inst_req;
    assign w_pop         = !i_stall && !w_empty;
    assign w_push        = (r_state == FETCH_REQ) && w_ack && !w_redirect;
    assign w_push_data   = '{pc: r_fetch_pc, inst: i_inst_rdata};
    assign w_count_after = {1'b0, w_count} + {2'b00, w_push} - {2'b00, w_pop};
    assign w_room_after  = (w_count_after < 3'd2);
    assign w_pc_next     = r_fetch_pc + 32'd4;

    fetch_queue u_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_redirect),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= FETCH_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_inst_addr <= '0;
            r_inst_req  <= 1'b0;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (w_redirect) begin
                        r_fetch_pc  <= w_target;
                        r_inst_addr <= w_target;
                        r_inst_req  <= 1'b1;
                        r_state     <= FETCH_REQ;
                    end else if (!w_full || w_pop) begin
                        r_inst_addr <= r_fetch_pc;
                        r_inst_req  <= 1'b1;
                        r_state     <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_target;
                        // An unanswered request must run to completion before retargeting.
                        if (w_ack) begin
                            r_inst_addr <= w_target;
                        end else begin
                            r_state <= FETCH_DISCARD;
                        end
                    end else if (w_ack) begin
                        r_fetch_pc <= w_pc_next;
                        if (w_room_after) begin
                            r_inst_addr <= w_pc_next;
                        end else begin
                            r_inst_req <= 1'b0;
                            r_state    <= FETCH_IDLE;
                        end
                    end
                end
                FETCH_DISCARD: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_target;
                    end
                    if (w_ack) begin
                        r_inst_addr <= w_redirect ? w_target : r_fetch_pc;
                        r_state     <= FETCH_REQ;
                    end
                end
                default: begin
                    r_state    <= FETCH_IDLE;
                    r_inst_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_inst_req  = r_inst_req;
    assign o_inst_addr = r_inst_addr;
    assign o_if_valid  = !w_empty;
    assign o_if_pc     = w_empty ? '0 : w_head.pc;
    assign o_if_inst   = w_empty ? ZeroWord : w_head.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        stall, flush, branch, spur;
    logic [31:0] new_pc, target;
    logic        req, ack, valid;
    logic [31:0] addr, rdata, pc, inst;
    logic        branch2;
    logic [31:0] target2;
    logic        req2, ack2, valid2;
    logic [31:0] addr2, rdata2, pc2, inst2;

    int mem_lat;
    int r_wait;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ack    = (req && (r_wait == mem_lat - 1)) || spur;
    assign rdata  = addr ^ KEY;
    assign ack2   = req2;
    assign rdata2 = addr2 ^ KEY;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_wait <= 0;
        else if (req && ack) r_wait <= 0;
        else if (req)        r_wait <= r_wait + 1;
        else                 r_wait <= 0;
    end

    inst_fetch u_dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_new_pc        (new_pc),
        .i_branch_flag   (branch),
        .i_branch_target (target),
        .o_inst_req      (req),
        .o_inst_addr     (addr),
        .i_inst_ack      (ack),
        .i_inst_rdata    (rdata),
        .o_if_valid      (valid),
        .o_if_pc         (pc),
        .o_if_inst       (inst)
    );

    inst_fetch #(.RESET_PC(32'hBFC0_0000)) u_dut2 (
        .i_clk           (clk),
        .i_rst_n         (rst2_n),
        .i_stall         (1'b0),
        .i_flush         (1'b0),
        .i_new_pc        (32'h0),
        .i_branch_flag   (branch2),
        .i_branch_target (target2),
        .o_inst_req      (req2),
        .o_inst_addr     (addr2),
        .i_inst_ack      (ack2),
        .i_inst_rdata    (rdata2),
        .o_if_valid      (valid2),
        .o_if_pc         (pc2),
        .o_if_inst       (inst2)
    );

    typedef struct {
        logic        stall, flush, branch, spur;
        logic [31:0] new_pc, target;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(input logic s, input logic f, input logic b, input logic sp,
                                input logic [31:0] np, input logic [31:0] tg,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.flush = f; v.branch = b; v.spur = sp;
        v.new_pc = np; v.target = tg;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pend, last_pc;
        logic        prev_req, prev_ack, seen;
        logic [31:0] prev_addr;
        int          last_cyc, n_valid, k;

        rst_n = 1'b0; rst2_n = 1'b0;
        stall = 0; flush = 0; branch = 0; spur = 0; new_pc = 0; target = 0;
        branch2 = 0; target2 = 0; mem_lat = 1;

        //             st fl br sp new_pc        target        req addr          v  pc
        vt[0]  = mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0);
        vt[1]  = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 32'h0);
        vt[2]  = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h4,        1, 32'h0);
        vt[3]  = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h8,        1, 32'h4);
        vt[4]  = mk(1, 0, 0, 0, 32'h0,        32'h0,        1, 32'hC,        1, 32'h8);
        vt[5]  = mk(1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h8);
        vt[6]  = mk(1, 0, 0, 1, 32'h0,        32'h0,        0, 32'h0,        1, 32'h8);
        vt[7]  = mk(1, 0, 0, 1, 32'h0,        32'h0,        0, 32'h0,        1, 32'h8);
        vt[8]  = mk(1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h8);
        vt[9]  = mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h8);
        vt[10] = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h10,       1, 32'hC);
        vt[11] = mk(0, 0, 1, 0, 32'h0,        32'h100,      1, 32'h14,       1, 32'h10);
        vt[12] = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h100,      0, 32'h0);
        vt[13] = mk(0, 1, 1, 0, 32'h23,       32'h100,      1, 32'h104,      1, 32'h100);
        vt[14] = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h20,       0, 32'h0);
        vt[15] = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h24,       1, 32'h20);
        vt[16] = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h28,       1, 32'h24);

        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {31'b0, req}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);

        // Zero-wait memory: streaming, stall, spurious ack, branch, flush+branch.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            stall = vt[i].stall; flush = vt[i].flush; branch = vt[i].branch; spur = vt[i].spur;
            new_pc = vt[i].new_pc; target = vt[i].target;
            #1;
            check($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vt[i].exp_req});
            if (vt[i].exp_req) check($sformatf("v%0d_addr", i), addr, vt[i].exp_addr);
            check($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vt[i].exp_valid});
            if (vt[i].exp_valid) begin
                check($sformatf("v%0d_pc", i), pc, vt[i].exp_pc);
                check($sformatf("v%0d_inst", i), inst, vt[i].exp_pc ^ KEY);
            end else begin
                check($sformatf("v%0d_inst_zero", i), inst, 32'h0);
            end
            @(negedge clk);
        end
        stall = 0; flush = 0; branch = 0; spur = 0;

        // 3-cycle latency memory.
        rst_n = 1'b0; mem_lat = 3;
        @(negedge clk);
        rst_n = 1'b1;
        prev_req = 0; prev_ack = 0; prev_addr = 0; n_valid = 0; last_cyc = 0; last_pc = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (prev_req && !prev_ack) begin
                check($sformatf("lat_hold_req_c%0d", c), {31'b0, req}, 32'h1);
                check($sformatf("lat_hold_addr_c%0d", c), addr, prev_addr);
            end
            if (valid) begin
                if (n_valid == 0) begin
                    check("lat_first_pc", pc, 32'h0);
                    check("lat_first_cycle", c, 4);
                end else begin
                    check($sformatf("lat_pc_c%0d", c), pc, last_pc + 32'd4);
                    check($sformatf("lat_gap_c%0d", c), c - last_cyc, 3);
                end
                check($sformatf("lat_inst_c%0d", c), inst, pc ^ KEY);
                last_pc = pc; last_cyc = c; n_valid++;
            end
            prev_req = req; prev_ack = ack; prev_addr = addr;
            @(negedge clk);
        end
        check("lat_count", n_valid, 6);

        // Branch while a request waits: the pending data must be discarded.
        #1;
        pend = addr;
        check("disc_req_pending", {31'b0, req}, 32'h1);
        check("disc_no_ack", {31'b0, ack}, 32'h0);
        branch = 1; target = 32'h100;
        @(negedge clk);
        branch = 0;
        #1;
        seen = 0;
        k = 0;
        while (!seen && k < 8) begin
            check($sformatf("disc_req_k%0d", k), {31'b0, req}, 32'h1);
            check($sformatf("disc_addr_k%0d", k), addr, pend);
            check($sformatf("disc_valid_k%0d", k), {31'b0, valid}, 32'h0);
            if (ack) seen = 1;
            @(negedge clk); #1;
            k++;
        end
        check("disc_ack_seen", {31'b0, seen}, 32'h1);
        check("disc_redir_addr", addr, 32'h100);
        k = 0;
        while (!valid && k < 8) begin
            @(negedge clk); #1;
            k++;
        end
        check("disc_valid", {31'b0, valid}, 32'h1);
        check("disc_pc", pc, 32'h100);
        check("disc_inst", inst, 32'h100 ^ KEY);

        // Asynchronous reset while a request is outstanding.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'b0, req}, 32'h0);
        check("arst_addr", addr, 32'h0);
        check("arst_valid", {31'b0, valid}, 32'h0);
        check("arst_pc", pc, 32'h0);
        check("arst_inst", inst, 32'h0);

        // Second instance: non-zero reset PC and address wrap.
        @(negedge clk);
        #1;
        check("d2_rst_req", {31'b0, req2}, 32'h0);
        check("d2_rst_addr", addr2, 32'h0);
        rst2_n = 1'b1;
        @(negedge clk); #1;
        check("d2_first_req", {31'b0, req2}, 32'h1);
        check("d2_first_addr", addr2, 32'hBFC0_0000);
        branch2 = 1; target2 = 32'hFFFF_FFFF;
        @(negedge clk);
        branch2 = 0;
        #1;
        check("d2_wrap_addr", addr2, 32'hFFFF_FFFC);
        check("d2_dropped", {31'b0, valid2}, 32'h0);
        @(negedge clk); #1;
        check("d2_top_pc", pc2, 32'hFFFF_FFFC);
        check("d2_top_inst", inst2, 32'hFFFF_FFFC ^ KEY);
        check("d2_wrap_req_addr", addr2, 32'h0);
        @(negedge clk); #1;
        check("d2_wrap_valid", {31'b0, valid2}, 32'h1);
        check("d2_wrap_pc", pc2, 32'h0);
        check("d2_wrap_inst", inst2, KEY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator for the OpenMIPS pipeline: generates the PC stream, issues single-outstanding read requests to instruction memory over a req/ack handshake, buffers returned words in a 2-entry queue and presents `{pc, inst}` to the IF/ID register. It sits between `ctrl` (stall/flush), `ex`/`id` (branch redirect) and the instruction-memory port. It tolerates multi-cycle memory latency and drops data belonging to squashed fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  IF/ID hold from `ctrl`; head entry not consumed
- `flush`  in  1  exception redirect from `ctrl`
- `new_pc`  in  32  exception handler address, used with `flush`
- `branch_flag`  in  1  branch/jump taken
- `branch_target`  in  32  branch destination
- `inst_req`  out  1  memory read request
- `inst_addr`  out  32  word-aligned read address
- `inst_ack`  in  1  read data valid this cycle
- `inst_rdata`  in  32  read data
- `if_valid`  out  1  `if_pc`/`if_inst` hold a real instruction
- `if_pc`  out  32  PC of presented instruction
- `if_inst`  out  32  presented instruction; `ZeroWord` when `!if_valid`

## Operation
- State machine (`fetch_pc` register plus 2-entry queue):
  - IDLE: no request outstanding. Move to REQ when queue occupancy + 0 < 2 and no redirect this cycle.
  - REQ: `inst_req`=1, `inst_addr`=`fetch_pc`. On `inst_ack`: push `{fetch_pc, inst_rdata}`, `fetch_pc += 4`; stay in REQ if queue still has a free slot after push/pop, else IDLE.
  - DISCARD: request outstanding when a redirect arrived; `inst_req` stays 1 at the old address until `inst_ack`, data dropped, then REQ at the redirected PC.
- Redirect: `flush` has priority over `branch_flag`; both same cycle -> `new_pc`. Redirect clears the queue in the same edge, loads `fetch_pc`; REQ->DISCARD if ack not received that cycle, REQ-with-ack-this-cycle -> data dropped, go to REQ.
- Queue pops head on `!stall && if_valid`. Push and pop in the same cycle allowed when full.
- `inst_addr[1:0]` always 2'b00; targets' low 2 bits ignored. PC wraps 32'hFFFF_FFFC -> 0.
- `if_inst` = `ZeroWord` whenever queue empty.

## Timing
- Reset (async assert, sync-deasserted use): `inst_req`=0, `inst_addr`=0, `if_valid`=0, `if_pc`=0, `if_inst`=0, queue empty, state IDLE, `fetch_pc`=`RESET_PC`. First request at the first edge after deassertion.
- Reset mid-request abandons it; memory must accept a dropped req.
- Handshake: once raised, `inst_req` and `inst_addr` hold stable until the cycle `inst_ack`=1. At most one request outstanding. Ack in the same cycle req rises is legal (zero-wait memory).
- Zero-wait memory, no stall: one instruction per cycle after a 2-cycle startup (req cycle, then queue output).
- Redirect-to-valid: redirect in cycle N -> request to target at N+1 (IDLE/REQ) or after pending ack (DISCARD); instruction at `if_*` one cycle after its ack.
- `inst_ack` while not requesting: ignored.

## Structure
- Widths/constants (`InstAddrBus`, `InstBus`, `ZeroWord`) and state encodings `FETCH_IDLE/FETCH_REQ/FETCH_DISCARD` go in shared `defines.v`.
- One sub-module: `fetch_queue`, 2-entry {pc, inst} FIFO with push/pop/clear, full/empty.

## Test plan
- Reset release, zero-wait memory returning `addr`: `if_pc` = 0,4,8,… on consecutive cycles, `if_inst` matches, first `if_valid` 2 cycles after reset.
- 3-cycle-latency memory: `inst_addr` stable across wait cycles, throughput one instruction per 3 cycles, no duplicates/gaps.
- `stall` held 5 cycles: queue fills to 2, `inst_req` drops, outputs frozen; on release 0x8,0xC then 0x10 with no loss.
- `branch_flag` with target 0x100 while a request to 0x14 waits: 0x14 data never appears, next `if_pc`=0x100.
- `flush` (new_pc 0x20) and `branch_flag` (0x100) same cycle: next `if_pc`=0x20.
- `rst_n` low during outstanding request, then `RESET_PC`=0xBFC0_0000: all outputs 0, first `inst_addr`=0xBFC0_0000; PC 0xFFFF_FFFC followed by 0x0.
